// File: rtl/rtc_bus_writer.sv
// Write-side master for the RTC's multiplexed AD port: one request becomes an
// address phase, a data phase and a recovery gap, each with programmable dwell.
module rtc_bus_writer #(
    parameter int unsigned T_SETUP  = 2,
    parameter int unsigned T_STROBE = 4,
    parameter int unsigned T_HOLD   = 2,
    parameter int unsigned T_GAP    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       a_d
);

    localparam logic [3:0] LOAD_SETUP  = 4'(T_SETUP - 1);
    localparam logic [3:0] LOAD_STROBE = 4'(T_STROBE - 1);
    localparam logic [3:0] LOAD_HOLD   = 4'(T_HOLD - 1);
    localparam logic [3:0] LOAD_GAP    = 4'(T_GAP - 1);

    typedef enum logic [2:0] {
        IDLE,
        A_SETUP,
        A_STROBE,
        A_HOLD,
        D_SETUP,
        D_STROBE,
        D_HOLD,
        GAP
    } state_t;

    state_t     state;
    logic [3:0] count;
    logic [7:0] addr_q;
    logic [7:0] data_q;

    // This block never reads the RTC, so the read strobe is tied inactive.
    assign rd_n = 1'b1;

    // Outputs are set on the transition into each state, so every bus pin
    // is a flop and the values seen in a state are already stable on entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            count  <= 4'd0;
            addr_q <= 8'h00;
            data_q <= 8'h00;
            busy   <= 1'b0;
            done   <= 1'b0;
            ad_out <= 8'h00;
            ad_oe  <= 1'b0;
            cs_n   <= 1'b1;
            wr_n   <= 1'b1;
            a_d    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        addr_q <= addr;
                        data_q <= data;
                        state  <= A_SETUP;
                        count  <= LOAD_SETUP;
                        busy   <= 1'b1;
                        ad_out <= addr;
                        ad_oe  <= 1'b1;
                        cs_n   <= 1'b0;
                        wr_n   <= 1'b1;
                        a_d    <= 1'b1;
                    end
                end

                A_SETUP: begin
                    ad_out <= addr_q;
                    if (count == 4'd0) begin
                        state <= A_STROBE;
                        count <= LOAD_STROBE;
                        wr_n  <= 1'b0;
                    end else begin
                        count <= count - 4'd1;
                    end
                end

                A_STROBE: begin
                    ad_out <= addr_q;
                    if (count == 4'd0) begin
                        state <= A_HOLD;
                        count <= LOAD_HOLD;
                        wr_n  <= 1'b1;
                    end else begin
                        count <= count - 4'd1;
                    end
                end

                // cs_n stays low across the phase boundary; only AD and a_d move.
                A_HOLD: begin
                    if (count == 4'd0) begin
                        state  <= D_SETUP;
                        count  <= LOAD_SETUP;
                        ad_out <= data_q;
                        a_d    <= 1'b0;
                    end else begin
                        count <= count - 4'd1;
                    end
                end

                D_SETUP: begin
                    if (count == 4'd0) begin
                        state <= D_STROBE;
                        count <= LOAD_STROBE;
                        wr_n  <= 1'b0;
                    end else begin
                        count <= count - 4'd1;
                    end
                end

                D_STROBE: begin
                    if (count == 4'd0) begin
                        state <= D_HOLD;
                        count <= LOAD_HOLD;
                        wr_n  <= 1'b1;
                    end else begin
                        count <= count - 4'd1;
                    end
                end

                D_HOLD: begin
                    if (count == 4'd0) begin
                        state  <= GAP;
                        count  <= LOAD_GAP;
                        cs_n   <= 1'b1;
                        ad_oe  <= 1'b0;
                        ad_out <= 8'h00;
                        a_d    <= 1'b1;
                    end else begin
                        count <= count - 4'd1;
                    end
                end

                GAP: begin
                    if (count == 4'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        count <= count - 4'd1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    count  <= 4'd0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    ad_out <= 8'h00;
                    ad_oe  <= 1'b0;
                    cs_n   <= 1'b1;
                    wr_n   <= 1'b1;
                    a_d    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_bus_writer.sv
// Bench for rtc_bus_writer: a default instance and an all-ones instance share
// stimulus and are each compared every cycle against a cycle-index model.
module tb_rtc_bus_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] data = 8'h00;

    logic       busy0, done0, ad_oe0, cs_n0, wr_n0, rd_n0, a_d0;
    logic [7:0] ad_out0;
    logic       busy1, done1, ad_oe1, cs_n1, wr_n1, rd_n1, a_d1;
    logic [7:0] ad_out1;

    int passCount = 0;
    int checkCount = 0;
    bit checking = 1'b0;

    localparam logic [14:0] RESET_VEC = {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    int tSetup[2]  = '{2, 1};
    int tStrobe[2] = '{4, 1};
    int tHold[2]   = '{2, 1};
    int tGap[2]    = '{4, 1};

    int         cyc[2] = '{0, 0};
    logic [7:0] modelAddr[2];
    logic [7:0] modelData[2];
    int         doneSeen0 = 0;
    int         doneModel0 = 0;

    rtc_bus_writer dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .data(data),
        .busy(busy0), .done(done0), .ad_out(ad_out0), .ad_oe(ad_oe0),
        .cs_n(cs_n0), .wr_n(wr_n0), .rd_n(rd_n0), .a_d(a_d0)
    );

    rtc_bus_writer #(.T_SETUP(1), .T_STROBE(1), .T_HOLD(1), .T_GAP(1)) dut_min (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .data(data),
        .busy(busy1), .done(done1), .ad_out(ad_out1), .ad_oe(ad_oe1),
        .cs_n(cs_n1), .wr_n(wr_n1), .rd_n(rd_n1), .a_d(a_d1)
    );

    logic [14:0] obs0, obs1;
    assign obs0 = {busy0, done0, ad_out0, ad_oe0, cs_n0, wr_n0, rd_n0, a_d0};
    assign obs1 = {busy1, done1, ad_out1, ad_oe1, cs_n1, wr_n1, rd_n1, a_d1};

    always #5 clk = ~clk;

    function automatic int busyLen(input int i);
        return 2 * (tSetup[i] + tStrobe[i] + tHold[i]) + tGap[i];
    endfunction

    // Cycle n of a transfer (1 = first cycle after acceptance, 0 = idle).
    function automatic logic [14:0] expectedOut(input int i, input int n,
                                                input logic [7:0] a, input logic [7:0] d);
        int p;
        int off;
        logic [14:0] v;
        p = tSetup[i] + tStrobe[i] + tHold[i];
        v = RESET_VEC;
        if (n >= 1 && n <= 2 * p) begin
            off = (n <= p) ? n : n - p;
            v = {1'b1, 1'b0, (n <= p) ? a : d, 1'b1, 1'b0,
                 !(off > tSetup[i] && off <= tSetup[i] + tStrobe[i]), 1'b1, (n <= p)};
        end else if (n > 2 * p && n <= busyLen(i)) begin
            v[14] = 1'b1;
        end else if (n == busyLen(i) + 1) begin
            v[13] = 1'b1;
        end
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    endtask

    task automatic applyStimulus(input logic s, input logic [7:0] a, input logic [7:0] d,
                                 input int cycles);
        start = s;
        addr  = a;
        data  = d;
        repeat (cycles) @(negedge clk);
    endtask

    // Reference model: only the position within a transfer is tracked.
    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                cyc[i] <= 0;
            end else if ((cyc[i] == 0 || cyc[i] == busyLen(i) + 1) && start) begin
                cyc[i]       <= 1;
                modelAddr[i] <= addr;
                modelData[i] <= data;
            end else if (cyc[i] == busyLen(i) + 1) begin
                cyc[i] <= 0;
            end else if (cyc[i] != 0) begin
                cyc[i] <= cyc[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("bus_def", 32'(obs0), 32'(expectedOut(0, cyc[0], modelAddr[0], modelData[0])));
            checkOutput("bus_min", 32'(obs1), 32'(expectedOut(1, cyc[1], modelAddr[1], modelData[1])));
            if (done0) doneSeen0++;
            if (cyc[0] == busyLen(0) + 1) doneModel0++;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int busyCount0;
        int busyCount1;
        int wrLow1;

        repeat (2) @(negedge clk);
        checkOutput("reset_def", 32'(obs0), 32'(RESET_VEC));
        checkOutput("reset_min", 32'(obs1), 32'(RESET_VEC));
        reset = 1'b0;
        checking = 1'b1;
        applyStimulus(0, 8'h00, 8'h00, 2);

        // Single write, then corrupt inputs and pulse start in D_STROBE.
        applyStimulus(1, 8'h21, 8'h45, 1);
        applyStimulus(0, 8'h21, 8'h45, 10);
        applyStimulus(1, 8'hFF, 8'hFF, 1);
        applyStimulus(0, 8'hFF, 8'hFF, 15);

        // Back-to-back with start held high.
        applyStimulus(1, 8'h22, 8'h10, 21);
        applyStimulus(1, 8'h23, 8'h59, 21);
        applyStimulus(0, 8'h00, 8'h00, 25);

        // Reset while the default instance is in A_STROBE.
        applyStimulus(1, 8'h31, 8'h32, 1);
        applyStimulus(0, 8'h31, 8'h32, 3);
        checkOutput("wr_low_before_reset", 32'(wr_n0), 32'd0);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_def", 32'(obs0), 32'(RESET_VEC));
        checkOutput("async_reset_min", 32'(obs1), 32'(RESET_VEC));
        @(negedge clk);
        applyStimulus(0, 8'h00, 8'h00, 2);
        reset = 1'b0;
        applyStimulus(0, 8'h00, 8'h00, 2);

        // Isolated write: measure busy and strobe widths directly.
        busyCount0 = 0;
        busyCount1 = 0;
        wrLow1 = 0;
        applyStimulus(1, 8'h41, 8'h42, 1);
        start = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (busy0) busyCount0++;
            if (busy1) busyCount1++;
            if (!wr_n1) wrLow1++;
            @(negedge clk);
        end
        checkOutput("busy_len_def", 32'(busyCount0), 32'd20);
        checkOutput("busy_len_min", 32'(busyCount1), 32'd7);
        checkOutput("wr_low_min", 32'(wrLow1), 32'd2);

        // Randomized requests of varying spacing.
        for (int k = 0; k < 40; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                          int'($urandom_range(1, 8)));
        end
        applyStimulus(0, 8'h00, 8'h00, 25);

        checking = 1'b0;
        checkOutput("done_count", 32'(doneSeen0), 32'(doneModel0));
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/rtc_bus_writer.md
# rtc_bus_writer

Write-side bus master for the external RTC's multiplexed address/data port. Accepts one (register address, data byte) pair per request from the control logic, typically a counter-set value destined for an RTC time/date register, and drives a complete two-phase write cycle (address phase, then data phase) with programmable setup, strobe, hold and recovery times. It is the counterpart of the read-side capture registers that latch RTC data into the design. It issues `done` when the RTC may be addressed again.

## Interface
- `T_SETUP`, default 2: cycles `ad_out`, `a_d` and `cs_n` are stable before `wr_n` falls, each phase; legal range 1..15.
- `T_STROBE`, default 4: cycles `wr_n` is held low, each phase; legal range 1..15.
- `T_HOLD`, default 2: cycles `ad_out`, `a_d` and `cs_n` remain stable after `wr_n` rises, each phase; legal range 1..15.
- `T_GAP`, default 4: recovery cycles with `cs_n` high before `done`; legal range 1..15.

- `clk` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: reset, asynchronous, active-high.
- `start` input 1: write request; sampled only in IDLE.
- `addr` input 8: RTC register address; captured with `start`.
- `data` input 8: byte to write; captured with `start`.
- `busy` output 1: high from the cycle after acceptance until `done`.
- `done` output 1: one-cycle completion pulse.
- `ad_out` output 8: value driven on the RTC AD bus.
- `ad_oe` output 1: AD tri-state enable (1 = drive).
- `cs_n` output 1: RTC chip select, active-low.
- `wr_n` output 1: RTC write strobe, active-low.
- `rd_n` output 1: RTC read strobe; constant 1 in this block.
- `a_d` output 1: 1 = address phase, 0 = data phase.

## Operation
- States: IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, GAP.
- A 4-bit down-counter sets the dwell time of each state.
  - On entry to a state, the counter loads (parameter − 1).
  - The FSM advances when the counter reaches 0.
- IDLE:
  - `start` = 1 latches `addr` and `data` into internal registers and moves the FSM to A_SETUP.
  - `start` is ignored in every other state. No queueing; a request made while busy is lost.
- Address phase (A_*): `ad_out` = latched address, `a_d` = 1, `cs_n` = 0, `ad_oe` = 1. `wr_n` = 0 only in A_STROBE.
- Data phase (D_*): `ad_out` = latched data, `a_d` = 0, `cs_n` = 0, `ad_oe` = 1. `wr_n` = 0 only in D_STROBE.
- `cs_n` stays low continuously from the first A_SETUP cycle to the last D_HOLD cycle. It does not deassert between phases.
- GAP: `cs_n` = 1, `ad_oe` = 0, `ad_out` = 0, `a_d` = 1. The FSM returns to IDLE after T_GAP cycles.
- `done` = 1 for exactly the first IDLE cycle after GAP.
- `busy` = 1 in every non-IDLE state.
- Changes on `addr` or `data` after acceptance have no effect on the write in progress.
- All outputs are registered; no combinational path exists from inputs to outputs.

## Timing
- Reset values, applied immediately while `reset` = 1:
  - FSM in IDLE; counter and latches cleared.
  - `busy` = 0, `done` = 0, `ad_out` = 0x00, `ad_oe` = 0.
  - `cs_n` = 1, `wr_n` = 1, `rd_n` = 1, `a_d` = 1.
- Reset mid-transfer aborts the cycle at once: `cs_n` and `wr_n` go high asynchronously and no `done` is issued.
- With `start` sampled high at edge k:
  - A_SETUP is visible on the outputs from edge k+1.
  - `wr_n` first falls at edge k+1+T_SETUP.
- Per-phase length = T_SETUP + T_STROBE + T_HOLD cycles.
- Total `busy` duration = 2·(T_SETUP+T_STROBE+T_HOLD) + T_GAP. With defaults this is 20 cycles.
- `done` rises on the same edge that `busy` falls.
- A new `start` is accepted in the `done` cycle. Back-to-back throughput is therefore one write per busy duration + 1 cycles.
- `wr_n` never toggles while `ad_out` or `a_d` changes. Every `ad_out`/`a_d` transition occurs only when `wr_n` = 1 and at least T_HOLD cycles after `wr_n` rose.

## Test plan
- Reset check: assert `reset` asynchronously mid-cycle -> all outputs take their reset values before the next clock edge.
- Single write with defaults: `start` with `addr` = 0x21, `data` = 0x45 ->
  - `ad_out` = 0x21 with `a_d` = 1 for 8 cycles, `wr_n` low in cycles 3-6.
  - Then `ad_out` = 0x45 with `a_d` = 0 for 8 cycles, `wr_n` low in cycles 11-14.
  - `cs_n` low for cycles 1-16, `busy` high for 20 cycles, `done` pulses once.
- Input change during transfer: change `addr`/`data` to 0xFF and pulse `start` in D_STROBE -> bus still shows 0x21/0x45, the extra `start` is ignored, and exactly one `done` occurs.
- Back-to-back writes: hold `start` = 1 with 0x22/0x10, then 0x23/0x59 -> second write begins the cycle after `done`, with identical timing and no overlap of `cs_n`.
- Reset in A_STROBE: -> `wr_n` and `cs_n` go high immediately, no `done` is issued, and the next `start` completes normally.
- Parameter corner: all parameters = 1 -> `busy` = 7 cycles, and `wr_n` is low for exactly 1 cycle per phase.
